// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for pll_reset_sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST   = 3'd0,
        WAITLOCK = 3'd1,
        SETTLE   = 3'd2,
        RUN      = 3'd3,
        FAIL     = 3'd4
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// sync2: two-flop synchroniser, cleared to 0 by synchronous active-low reset
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock sequencer with retry and sticky failure.
// Define PLL_LOCKLOSS_RECOVER_EN to re-reset the PLL on lock loss in RUN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pll_locked,
    input  logic                               retry_req,
    output logic                               pll_rst,
    output logic                               sys_reset_n,
    output logic                               pll_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RC_MAX      = RW'(MAX_RETRIES);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rc_nxt, rc_inc;
    logic          locked_s;

    sync2 #(.W(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    assign rc_inc = (retry_count == RC_MAX) ? retry_count : retry_count + RW'(1);

    always_comb begin
        nxt    = state;
        rc_nxt = retry_count;
        case (state)
            PLLRST:   if (cnt == RST_LAST) nxt = WAITLOCK;
            WAITLOCK: begin
                if (locked_s) nxt = SETTLE;
                else if (cnt == TO_LAST) begin
                    rc_nxt = rc_inc;
                    nxt    = (rc_inc == RC_MAX) ? FAIL : PLLRST;
                end
            end
            SETTLE: begin
                if (!locked_s) nxt = WAITLOCK;
                else if (cnt == STABLE_LAST) begin
                    nxt    = RUN;
                    rc_nxt = '0;
                end
            end
`ifdef PLL_LOCKLOSS_RECOVER_EN
            RUN: begin
                if (!locked_s) begin
                    nxt    = PLLRST;
                    rc_nxt = '0;
                end
            end
`else
            RUN:      if (!locked_s) nxt = SETTLE;
`endif
            FAIL: begin
                if (retry_req) begin
                    nxt    = PLLRST;
                    rc_nxt = '0;
                end
            end
            default:  nxt = PLLRST;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= PLLRST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            pll_fail    <= 1'b0;
            retry_count <= '0;
        end else begin
            state       <= nxt;
            cnt         <= (nxt != state) ? '0 : cnt + CW'(1);
            pll_rst     <= (nxt == PLLRST) || (nxt == FAIL);
            sys_reset_n <= (nxt == RUN);
            pll_fail    <= (nxt == FAIL);
            retry_count <= rc_nxt;
        end
    end

endmodule
